// File: rtl/mips_pkg.sv
// Shared types and constants for the register-port sequencer: FSM states,
// MIPS opcodes of interest, register numbers and the latched decode record.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_RS   = 3'd1,
    RD_RT   = 3'd2,
    OPS     = 3'd3,
    WAIT_WB = 3'd4,
    WR      = 3'd5
  } seq_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam int REG_T0 = 8;
  localparam int REG_S0 = 16;
  localparam int REG_S7 = 23;

  // Everything the sequencer needs from one instruction, captured at accept.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       has_wb;
    logic       rs_zero;
    logic       rs_err;
    logic       rt_zero;
    logic       rt_err;
    logic       dest_ok;
    logic       dest_err;
  } decode_t;

  function automatic logic is_no_wb_opcode(input logic [5:0] opcode);
    return (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/reg_instr_decode.sv
// Combinational instruction decode: register fields, destination selection,
// write-back need and implemented-range checks for every register operand.
module reg_instr_decode
  import mips_pkg::*;
#(
  parameter int REG_LO   = REG_T0,
  parameter int REG_HI   = REG_S7,
  parameter int ZERO_REG = REG_S0
) (
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [5:0] w_opcode;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [4:0] w_dest;
  logic       w_unused_low;

  function automatic logic in_range(input logic [4:0] a);
    return (int'(a) >= REG_LO) && (int'(a) <= REG_HI);
  endfunction

  // Register 0, the hard-wired zero register and unimplemented ones all read as 0.
  function automatic logic forced_zero(input logic [4:0] a);
    return (a == 5'd0) || (int'(a) == ZERO_REG) || !in_range(a);
  endfunction

  function automatic logic bad_addr(input logic [4:0] a);
    return (a != 5'd0) && !in_range(a);
  endfunction

  assign w_opcode     = instr[31:26];
  assign w_rs         = instr[25:21];
  assign w_rt         = instr[20:16];
  assign w_rd         = instr[15:11];
  assign w_dest       = (w_opcode == OP_RTYPE) ? w_rd : w_rt;
  assign w_unused_low = ^instr[10:0];

  always_comb begin
    dec          = '0;
    dec.rs       = w_rs;
    dec.rt       = w_rt;
    dec.dest     = w_dest;
    dec.has_wb   = !is_no_wb_opcode(w_opcode);
    dec.rs_zero  = forced_zero(w_rs);
    dec.rs_err   = bad_addr(w_rs);
    dec.rt_zero  = forced_zero(w_rt);
    dec.rt_err   = bad_addr(w_rt);
    dec.dest_ok  = !forced_zero(w_dest);
    dec.dest_err = bad_addr(w_dest);
  end

endmodule

// File: rtl/reg_port_sequencer.sv
// Sole master of the single-port register file: reads rs then rt, hands both
// operands to execute, then writes the returned result to the destination.
module reg_port_sequencer
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int REG_LO   = REG_T0,
  parameter int REG_HI   = REG_S7,
  parameter int ZERO_REG = REG_S0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              addr_err
);

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  decode_t           w_dec;
  decode_t           r_dec;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_wb_data;
  logic              w_accept;

  reg_instr_decode #(
    .REG_LO  (REG_LO),
    .REG_HI  (REG_HI),
    .ZERO_REG(ZERO_REG)
  ) u_decode (
    .instr(instr),
    .dec  (w_dec)
  );

  assign w_accept = (r_state == IDLE) && instr_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operands are captured at the end of each read cycle and held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_accept) begin
        r_dec <= w_dec;
      end
      if (r_state == RD_RS) begin
        r_op_a <= r_dec.rs_zero ? '0 : reg_rdata;
      end
      if (r_state == RD_RT) begin
        r_op_b <= r_dec.rt_zero ? '0 : reg_rdata;
      end
      if ((r_state == WAIT_WB) && wb_valid) begin
        r_wb_data <= wb_data;
      end
    end
  end

  // Port outputs decode straight from the state so reset removes them immediately.
  always_comb begin
    w_state_next = r_state;
    instr_ready  = 1'b0;
    op_valid     = 1'b0;
    wb_ready     = 1'b0;
    reg_write    = 1'b0;
    reg_addr     = '0;
    reg_wdata    = '0;
    addr_err     = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_state_next = RD_RS;
        end
      end
      RD_RS: begin
        reg_addr     = ADDR_W'(r_dec.rs);
        addr_err     = r_dec.rs_err;
        w_state_next = RD_RT;
      end
      RD_RT: begin
        reg_addr     = ADDR_W'(r_dec.rt);
        addr_err     = r_dec.rt_err;
        w_state_next = OPS;
      end
      OPS: begin
        op_valid = 1'b1;
        if (op_ready) begin
          w_state_next = r_dec.has_wb ? WAIT_WB : IDLE;
        end
      end
      WAIT_WB: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          w_state_next = WR;
        end
      end
      WR: begin
        reg_write    = r_dec.dest_ok;
        reg_addr     = ADDR_W'(r_dec.dest);
        reg_wdata    = r_wb_data;
        addr_err     = r_dec.dest_err;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Self-checking bench for reg_port_sequencer: directed vector table, random
// instructions against a phase-level reference model, and reset corner cases.
module tb_reg_port_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic        wb_ready;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        addr_err;

  reg_port_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .wb_data    (wb_data),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .reg_write  (reg_write),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file contents seen by the DUT; unimplemented and zero registers hold junk.
  logic [31:0] rf [32];
  assign reg_rdata = rf[reg_addr];

  typedef struct packed {
    logic        op_valid;
    logic        wb_ready;
    logic        reg_write;
    logic        addr_err;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } trace_t;

  trace_t obs [64];
  int     obs_len;
  trace_t exp_tr [64];
  int     exp_len;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  function automatic trace_t mk(input logic ov, input logic wr, input logic we, input logic er,
                                input logic [4:0] ad, input logic [31:0] wd,
                                input logic [31:0] a, input logic [31:0] b);
    trace_t t;
    t.op_valid = ov; t.wb_ready = wr; t.reg_write = we; t.addr_err = er;
    t.reg_addr = ad; t.reg_wdata = wd; t.op_a = a; t.op_b = b;
    return t;
  endfunction

  function automatic logic usable(input logic [4:0] r);
    return (r >= 5'd8) && (r <= 5'd23) && (r != 5'd16);
  endfunction

  function automatic logic bad(input logic [4:0] r);
    return (r != 5'd0) && ((r < 5'd8) || (r > 5'd23));
  endfunction

  // Reference: the instruction walks through read, read, operand, [wait, write] phases.
  task automatic build_model(input logic [31:0] ins, input int rdy, input int wdly, input logic [31:0] wbd);
    logic [5:0]  opc;
    logic [4:0]  rs, rt, dest;
    logic        has_wb;
    logic [31:0] va, vb;
    opc    = ins[31:26];
    rs     = ins[25:21];
    rt     = ins[20:16];
    dest   = (opc == 6'h00) ? ins[15:11] : rt;
    has_wb = !(opc == 6'h2B || opc == 6'h04 || opc == 6'h05);
    va     = usable(rs) ? rf[rs] : 32'd0;
    vb     = usable(rt) ? rf[rt] : 32'd0;
    exp_len = 0;
    exp_tr[exp_len++] = mk(0, 0, 0, bad(rs), rs, 0, 0, 0);
    exp_tr[exp_len++] = mk(0, 0, 0, bad(rt), rt, 0, 0, 0);
    for (int i = 0; i <= rdy; i++) exp_tr[exp_len++] = mk(1, 0, 0, 0, 0, 0, va, vb);
    if (has_wb) begin
      for (int i = 0; i <= wdly; i++) exp_tr[exp_len++] = mk(0, 1, 0, 0, 0, 0, 0, 0);
      exp_tr[exp_len++] = mk(0, 0, usable(dest), bad(dest), dest, wbd, 0, 0);
    end
  endtask

  // Offer one instruction and record every busy cycle; unrelated inputs carry junk.
  task automatic run_instr(input logic [31:0] ins, input int rdy, input int wdly, input logic [31:0] wbd);
    int  k;
    int  j;
    bit  done;
    k = 0; j = 0; done = 0; obs_len = 0;
    @(negedge clk);
    check("accept_ready", 64'(instr_ready), 64'd1);
    instr = ins; instr_valid = 1'b1; op_ready = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 60 && !done; c++) begin
      if (instr_ready) begin
        done = 1;
      end else begin
        obs[obs_len] = mk(op_valid, wb_ready, reg_write, addr_err, reg_addr, reg_wdata,
                          op_valid ? op_a : 32'd0, op_valid ? op_b : 32'd0);
        if (obs_len < 63) obs_len++;
        instr_valid = 1'($urandom_range(0, 1));
        instr       = $urandom;
        if (op_valid) begin
          op_ready = (k >= rdy);
          k++;
        end else begin
          op_ready = 1'($urandom_range(0, 1));
        end
        if (wb_ready) begin
          wb_valid = (j >= wdly);
          wb_data  = (j >= wdly) ? wbd : $urandom;
          j++;
        end else begin
          wb_valid = 1'($urandom_range(0, 1));
          wb_data  = $urandom;
        end
        @(negedge clk);
      end
    end
    instr_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
    if (!done) check("txn_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [31:0] ins;
    int          rdy;
    int          wdly;
    logic [31:0] wbd;
    logic [31:0] ea;
    logic [31:0] eb;
    int          nwr;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          nerr;
    int          len;
    logic        wbseen;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] first_a, first_b, got_wd;
    logic [4:0]  got_wa;
    int          nwr, nerr, n_ops;
    logic        wbseen, stable, found;
    logic [5:0]  opc;
    logic [31:0] rins;
    int          rrdy, rwdly;
    logic [31:0] rwbd;

    for (int i = 0; i < 32; i++) rf[i] = 32'hDEADBEEF;
    for (int i = 8; i <= 23; i++) rf[i] = 32'h0000_1000 + 32'(i);
    rf[16] = 32'hBAD0_0016;
    rf[17] = 32'd5;
    rf[9]  = 32'd7;

    //          instr         rdy wdly wbd            op_a          op_b          nwr wa  wd          nerr len wbseen
    vecs[0] = '{32'h02295020, 0,  0,   32'd12,        32'd5,        32'd7,        1,  10, 32'd12,     0,   5,  1'b1};
    vecs[1] = '{32'hAE480004, 0,  0,   32'h33,        32'h1012,     32'h1008,     0,  0,  32'd0,      0,   3,  1'b0};
    vecs[2] = '{32'h21100001, 0,  0,   32'd9,         32'h1008,     32'd0,        0,  0,  32'd0,      0,   5,  1'b1};
    vecs[3] = '{32'h00895020, 0,  0,   32'h55,        32'd0,        32'd7,        1,  10, 32'h55,     1,   5,  1'b1};
    vecs[4] = '{32'h02295020, 3,  2,   32'hABCD,      32'd5,        32'd7,        1,  10, 32'hABCD,   0,   10, 1'b1};
    vecs[5] = '{32'h0131F020, 0,  0,   32'h66,        32'd7,        32'd5,        0,  0,  32'd0,      1,   5,  1'b1};
    vecs[6] = '{32'h10180010, 1,  0,   32'h77,        32'd0,        32'd0,        0,  0,  32'd0,      1,   4,  1'b0};

    instr = '0; instr_valid = 0; op_ready = 0; wb_data = '0; wb_valid = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_instr_ready", 64'(instr_ready), 64'd1);
    check("rst_outputs", {op_valid, wb_ready, reg_write, addr_err}, 4'b0);
    check("rst_addr_wdata", {reg_addr, reg_wdata}, 37'd0);
    check("rst_ops", {op_a, op_b}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      run_instr(vecs[v].ins, vecs[v].rdy, vecs[v].wdly, vecs[v].wbd);
      nwr = 0; nerr = 0; n_ops = 0; wbseen = 0; stable = 1;
      first_a = '0; first_b = '0; got_wa = '0; got_wd = '0;
      for (int i = 0; i < obs_len; i++) begin
        if (obs[i].op_valid) begin
          if (n_ops == 0) begin first_a = obs[i].op_a; first_b = obs[i].op_b; end
          else if (obs[i].op_a != first_a || obs[i].op_b != first_b) stable = 0;
          n_ops++;
        end
        if (obs[i].reg_write) begin nwr++; got_wa = obs[i].reg_addr; got_wd = obs[i].reg_wdata; end
        if (obs[i].addr_err) nerr++;
        if (obs[i].wb_ready) wbseen = 1;
      end
      check($sformatf("v%0d_op_a", v), 64'(first_a), 64'(vecs[v].ea));
      check($sformatf("v%0d_op_b", v), 64'(first_b), 64'(vecs[v].eb));
      check($sformatf("v%0d_op_stable", v), 64'(stable), 64'd1);
      check($sformatf("v%0d_nwrites", v), 64'(nwr), 64'(vecs[v].nwr));
      if (vecs[v].nwr != 0)
        check($sformatf("v%0d_write", v), {got_wa, got_wd}, {vecs[v].wa, vecs[v].wd});
      check($sformatf("v%0d_addr_err", v), 64'(nerr), 64'(vecs[v].nerr));
      check($sformatf("v%0d_len", v), 64'(obs_len), 64'(vecs[v].len));
      check($sformatf("v%0d_wb_ready", v), 64'(wbseen), 64'(vecs[v].wbseen));
      check($sformatf("v%0d_rs_addr", v), 64'(obs[0].reg_addr), 64'(vecs[v].ins[25:21]));
      check($sformatf("v%0d_rt_addr", v), 64'(obs[1].reg_addr), 64'(vecs[v].ins[20:16]));
      $display("vec %0d instr=%08h cycles=%0d writes=%0d errs=%0d", v, vecs[v].ins, obs_len, nwr, nerr);
    end

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0:       opc = 6'h00;
        1:       opc = 6'h2B;
        2:       opc = 6'h04;
        3:       opc = 6'h05;
        4:       opc = 6'h08;
        default: opc = 6'($urandom);
      endcase
      rins  = {opc, 5'($urandom), 5'($urandom), 5'($urandom), 11'($urandom)};
      rrdy  = $urandom_range(0, 3);
      rwdly = $urandom_range(0, 3);
      rwbd  = $urandom;
      build_model(rins, rrdy, rwdly, rwbd);
      run_instr(rins, rrdy, rwdly, rwbd);
      check($sformatf("r%0d_len", t), 64'(obs_len), 64'(exp_len));
      for (int i = 0; i < obs_len && i < exp_len; i++) begin
        n_checks++;
        if (obs[i] !== exp_tr[i]) begin
          n_errors++;
          $display("FAIL r%0d_cycle%0d got=%h expected=%h", t, i, obs[i], exp_tr[i]);
        end
      end
      $display("rand %0d instr=%08h rdy=%0d wdly=%0d cycles=%0d", t, rins, rrdy, rwdly, obs_len);
    end

    // Reset while waiting for write-back: nothing may be written afterwards.
    @(negedge clk);
    instr = 32'h02295020; instr_valid = 1'b1; op_ready = 1'b1; wb_valid = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (wb_ready) found = 1;
      else @(negedge clk);
    end
    check("rstwb_reached", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstwb_ready", 64'(instr_ready), 64'd1);
    check("rstwb_outputs", {op_valid, wb_ready, reg_write, addr_err}, 4'b0);
    check("rstwb_addr_wdata_ops", {reg_addr, reg_wdata, op_a}, 69'd0);
    @(negedge clk);
    wb_valid = 1'b1; wb_data = 32'h77; rst_n = 1'b1;
    nwr = 0; nerr = 0;
    repeat (4) begin
      @(negedge clk);
      if (reg_write) nwr++;
      if (!instr_ready || wb_ready) nerr++;
    end
    check("rstwb_no_write", 64'(nwr), 64'd0);
    check("rstwb_idle", 64'(nerr), 64'd0);
    wb_valid = 1'b0; op_ready = 1'b0;
    $display("reset during WAIT_WB done writes=%0d", nwr);

    // Reset in the write cycle must drop the strobe without waiting for a clock.
    @(negedge clk);
    instr = 32'h02295020; instr_valid = 1'b1; op_ready = 1'b1; wb_valid = 1'b1; wb_data = 32'h99;
    @(negedge clk);
    instr_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (reg_write) found = 1;
      else @(negedge clk);
    end
    check("rstwr_reached", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_write_drop", {reg_write, reg_addr, reg_wdata}, 38'd0);
    check("rstwr_ready", 64'(instr_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1; op_ready = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("rstwr_idle", {instr_ready, reg_write}, 2'b10);
    $display("reset during WR done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
